// File: rtl/fwd_pkg.sv
// Shared types for the forwarding / load-use hazard controller.
package fwd_pkg;
  localparam int REG_ADDR_W  = 5;
  localparam int STALL_CNT_W = 16;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_t;

  typedef enum logic {
    RUN       = 1'b0,
    LOADSTALL = 1'b1
  } hz_state_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wren;
    logic                  isload;
  } shadow_entry_t;
endpackage

// File: rtl/forward_hazard_ctrl_if.sv
// Decode-stage issue bus and forwarding/stall responses of forward_hazard_ctrl.
interface forward_hazard_ctrl_if;
  import fwd_pkg::*;

  logic                   IssueValid;
  logic [REG_ADDR_W-1:0]  IssueRs1;
  logic [REG_ADDR_W-1:0]  IssueRs2;
  logic [REG_ADDR_W-1:0]  IssueRd;
  logic                   IssueWrEn;
  logic                   IssueIsLoad;
  logic                   Flush;
  logic [1:0]             FwdSelA;
  logic [1:0]             FwdSelB;
  logic                   Stall;
  logic [STALL_CNT_W-1:0] StallCount;

  modport master (
    output IssueValid, IssueRs1, IssueRs2, IssueRd, IssueWrEn, IssueIsLoad, Flush,
    input  FwdSelA, FwdSelB, Stall, StallCount
  );

  modport slave (
    input  IssueValid, IssueRs1, IssueRs2, IssueRd, IssueWrEn, IssueIsLoad, Flush,
    output FwdSelA, FwdSelB, Stall, StallCount
  );
endinterface

// File: rtl/fwd_stage_match.sv
// One shadow stage versus one decode source operand: does this stage produce the operand?
module fwd_stage_match
  import fwd_pkg::*;
(
  input  logic                  entryValid,
  input  logic                  entryWrEn,
  input  logic [REG_ADDR_W-1:0] entryRd,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic                  issueValid,
  output logic                  match
);
  assign match = entryValid & entryWrEn & (entryRd == rs) & issueValid;
endmodule

// File: rtl/forward_hazard_ctrl.sv
// Operand forwarding select and load-use stall control over an EX/MEM/WB shadow pipeline.
// Define FWD_WB_BYPASS_EN to store the WB entry and allow WB forwarding (select 11).
module forward_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter logic [STALL_CNT_W-1:0] STALL_CNT_INIT = '0
) (
  input logic                 CLK,
  input logic                 RST_N,
  forward_hazard_ctrl_if.slave bus
);

  function automatic fwd_sel_t pickSel(input logic [2:0] m);
    if (m[0]) return FWD_EX;
    if (m[1]) return FWD_MEM;
    if (m[2]) return FWD_WB;
    return FWD_RF;
  endfunction

  function automatic logic [STALL_CNT_W-1:0] satInc(input logic [STALL_CNT_W-1:0] v);
    return (v == {STALL_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  shadow_entry_t          issueEntry;
  shadow_entry_t          shadow_p0;
  shadow_entry_t          shadow_p1;
  hz_state_t              state;
  hz_state_t              nextState;
  logic                   hazard;
  logic                   stall;
  logic [2:0]             matchA;
  logic [2:0]             matchB;
  logic [STALL_CNT_W-1:0] stallCnt;
  logic                   unusedIsLoad;

  assign issueEntry = '{valid: bus.IssueValid, rd: bus.IssueRd,
                        wren: bus.IssueWrEn, isload: bus.IssueIsLoad};

  fwd_stage_match uMatchAEx  (.entryValid(shadow_p0.valid), .entryWrEn(shadow_p0.wren),
    .entryRd(shadow_p0.rd), .rs(bus.IssueRs1), .issueValid(bus.IssueValid), .match(matchA[0]));
  fwd_stage_match uMatchBEx  (.entryValid(shadow_p0.valid), .entryWrEn(shadow_p0.wren),
    .entryRd(shadow_p0.rd), .rs(bus.IssueRs2), .issueValid(bus.IssueValid), .match(matchB[0]));
  fwd_stage_match uMatchAMem (.entryValid(shadow_p1.valid), .entryWrEn(shadow_p1.wren),
    .entryRd(shadow_p1.rd), .rs(bus.IssueRs1), .issueValid(bus.IssueValid), .match(matchA[1]));
  fwd_stage_match uMatchBMem (.entryValid(shadow_p1.valid), .entryWrEn(shadow_p1.wren),
    .entryRd(shadow_p1.rd), .rs(bus.IssueRs2), .issueValid(bus.IssueValid), .match(matchB[1]));

`ifdef FWD_WB_BYPASS_EN
  shadow_entry_t shadow_p2;

  fwd_stage_match uMatchAWb  (.entryValid(shadow_p2.valid), .entryWrEn(shadow_p2.wren),
    .entryRd(shadow_p2.rd), .rs(bus.IssueRs1), .issueValid(bus.IssueValid), .match(matchA[2]));
  fwd_stage_match uMatchBWb  (.entryValid(shadow_p2.valid), .entryWrEn(shadow_p2.wren),
    .entryRd(shadow_p2.rd), .rs(bus.IssueRs2), .issueValid(bus.IssueValid), .match(matchB[2]));

  // WB is kept across a flush: it holds the older instruction leaving MEM.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) shadow_p2 <= '0;
    else        shadow_p2 <= shadow_p1;
  end

  assign unusedIsLoad = shadow_p2.isload;
`else
  // Regfile is write-before-read, so a WB producer is already visible in the regfile.
  assign matchA[2]    = 1'b0;
  assign matchB[2]    = 1'b0;
  assign unusedIsLoad = shadow_p1.isload;
`endif

  assign bus.FwdSelA    = pickSel(matchA);
  assign bus.FwdSelB    = pickSel(matchB);
  assign hazard         = shadow_p0.valid & shadow_p0.isload & (matchA[0] | matchB[0]);
  assign bus.Stall      = stall;
  assign bus.StallCount = stallCnt;

  always_comb begin
    nextState = state;
    stall     = 1'b0;
    unique case (state)
      RUN: begin
        stall = hazard & ~bus.Flush;
        if (hazard) nextState = LOADSTALL;
      end
      LOADSTALL: nextState = RUN;
      default:   nextState = RUN;
    endcase
    if (bus.Flush) nextState = RUN;
  end

  // Stage boundary: decode -> EX (bubble on stall/flush), EX -> MEM (cleared on flush).
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= RUN;
      shadow_p0 <= '0;
      shadow_p1 <= '0;
      stallCnt  <= STALL_CNT_INIT;
    end else begin
      state     <= nextState;
      shadow_p0 <= (stall || bus.Flush) ? '0 : issueEntry;
      shadow_p1 <= bus.Flush ? '0 : shadow_p0;
      if (stall) stallCnt <= satInc(stallCnt);
    end
  end

endmodule

// File: tb/tb_forward_hazard_ctrl.sv
// Directed bench for forward_hazard_ctrl: forwarding priority, load-use stall, flush, reset, saturation.
module tb_forward_hazard_ctrl;
  import fwd_pkg::*;

`ifdef FWD_WB_BYPASS_EN
  localparam logic [1:0] WB_EXP = 2'b11;
`else
  localparam logic [1:0] WB_EXP = 2'b00;
`endif

  logic clk  = 1'b0;
  logic rstN = 1'b1;
  int   total = 0;
  int   bad   = 0;

  forward_hazard_ctrl_if bus ();
  forward_hazard_ctrl_if bus2 ();

  forward_hazard_ctrl dut (.CLK(clk), .RST_N(rstN), .bus(bus));
  forward_hazard_ctrl #(.STALL_CNT_INIT(16'hFFFE)) dutSat (.CLK(clk), .RST_N(rstN), .bus(bus2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic wr, input logic ld, input logic fl);
    bus.IssueValid = v; bus.IssueRs1 = rs1; bus.IssueRs2 = rs2; bus.IssueRd = rd;
    bus.IssueWrEn = wr; bus.IssueIsLoad = ld; bus.Flush = fl;
    #1;
  endtask

  task automatic driveSat(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic wr, input logic ld);
    bus2.IssueValid = v; bus2.IssueRs1 = rs1; bus2.IssueRs2 = rs2; bus2.IssueRd = rd;
    bus2.IssueWrEn = wr; bus2.IssueIsLoad = ld; bus2.Flush = 1'b0;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    driveSat(0, 0, 0, 0, 0, 0);
    rstN = 1'b0;
    #1;
    chk("rst_selA", bus.FwdSelA, 2'b00);
    chk("rst_selB", bus.FwdSelB, 2'b00);
    chk("rst_stall", bus.Stall, 1'b0);
    chk("rst_cnt", bus.StallCount, 16'h0000);
    chk("rst_sat_cnt", bus2.StallCount, 16'hFFFE);
    #10 rstN = 1'b1;
    tick();

    // ADD r3, then ADD r6 reading r3
    drive(1, 1, 2, 3, 1, 0, 0);
    chk("first_selA", bus.FwdSelA, 2'b00);
    tick();
    drive(1, 3, 4, 6, 1, 0, 0);
    chk("ex_fwd_selA", bus.FwdSelA, 2'b01);
    chk("ex_fwd_selB", bus.FwdSelB, 2'b00);
    chk("ex_fwd_stall", bus.Stall, 1'b0);
    tick();
    drive(1, 3, 6, 8, 1, 0, 0);
    chk("mem_fwd_selA", bus.FwdSelA, 2'b10);
    chk("ex_fwd2_selB", bus.FwdSelB, 2'b01);
    tick();

    // LD r5, then use r5 on Rs2
    drive(1, 0, 0, 5, 1, 1, 0);
    tick();
    drive(1, 1, 5, 9, 1, 0, 0);
    chk("lu_stall", bus.Stall, 1'b1);
    chk("lu_selB_during", bus.FwdSelB, 2'b01);
    chk("lu_cnt_before", bus.StallCount, 16'd0);
    tick();
    chk("lu_cnt_after", bus.StallCount, 16'd1);
    chk("ls_stall", bus.Stall, 1'b0);
    chk("ls_selB", bus.FwdSelB, 2'b10);
    chk("ls_selA", bus.FwdSelA, 2'b00);
    tick();

    // three writers of r7, then readers
    drive(1, 0, 0, 7, 1, 0, 0); tick();
    drive(1, 0, 0, 7, 1, 0, 0); tick();
    drive(1, 0, 0, 7, 1, 0, 0); tick();
    drive(1, 7, 9, 0, 0, 0, 0);
    chk("young_selA", bus.FwdSelA, 2'b01);
    chk("young_selB", bus.FwdSelB, 2'b00);
    tick();
    drive(0, 7, 7, 0, 0, 0, 0);
    chk("novalid_selA", bus.FwdSelA, 2'b00);
    tick();
    drive(1, 7, 0, 0, 0, 0, 0);
    chk("wb_only_selA", bus.FwdSelA, WB_EXP);
    tick();

    // r0 is forwardable; a non-writing entry is not
    drive(1, 1, 1, 0, 1, 0, 0); tick();
    drive(1, 0, 0, 2, 0, 0, 0);
    chk("r0_selA", bus.FwdSelA, 2'b01);
    chk("r0_selB", bus.FwdSelB, 2'b01);
    tick();
    drive(1, 0, 2, 0, 0, 0, 0);
    chk("r0_mem_selA", bus.FwdSelA, 2'b10);
    chk("nowren_selB", bus.FwdSelB, 2'b00);
    tick();

    // load-use hazard coinciding with flush
    drive(1, 0, 0, 5, 1, 1, 0); tick();
    drive(1, 5, 5, 5, 1, 0, 1);
    chk("fl_stall", bus.Stall, 1'b0);
    chk("fl_selA", bus.FwdSelA, 2'b01);
    tick();
    drive(1, 5, 5, 0, 0, 0, 0);
    chk("fl_cnt", bus.StallCount, 16'd1);
    chk("fl_after_stall", bus.Stall, 1'b0);
    chk("fl_after_selA", bus.FwdSelA, 2'b00);
    chk("fl_after_selB", bus.FwdSelB, 2'b00);
    tick();

    // Rs1 == Rs2 both depend on a load
    drive(1, 0, 0, 4, 1, 1, 0); tick();
    drive(1, 4, 4, 12, 1, 0, 0);
    chk("dual_stall", bus.Stall, 1'b1);
    chk("dual_selA", bus.FwdSelA, 2'b01);
    chk("dual_selB", bus.FwdSelB, 2'b01);
    tick();
    chk("dual_cnt", bus.StallCount, 16'd2);
    chk("dual_ls_stall", bus.Stall, 1'b0);
    chk("dual_ls_selA", bus.FwdSelA, 2'b10);
    chk("dual_ls_selB", bus.FwdSelB, 2'b10);
    tick();
    chk("dual_cnt_once", bus.StallCount, 16'd2);

    // reset while in LOADSTALL
    drive(1, 0, 0, 10, 1, 1, 0); tick();
    drive(1, 10, 0, 11, 1, 0, 0);
    chk("pre_rst_stall", bus.Stall, 1'b1);
    tick();
    chk("pre_rst_cnt", bus.StallCount, 16'd3);
    chk("pre_rst_selA", bus.FwdSelA, 2'b10);
    rstN = 1'b0;
    #1;
    chk("mid_rst_selA", bus.FwdSelA, 2'b00);
    chk("mid_rst_selB", bus.FwdSelB, 2'b00);
    chk("mid_rst_stall", bus.Stall, 1'b0);
    chk("mid_rst_cnt", bus.StallCount, 16'd0);
    #2 rstN = 1'b1;
    tick();
    drive(1, 10, 10, 0, 0, 0, 0);
    chk("post_rst_selA", bus.FwdSelA, 2'b00);
    chk("post_rst_stall", bus.Stall, 1'b0);
    tick();
    chk("post_rst_cnt", bus.StallCount, 16'd0);
    drive(0, 0, 0, 0, 0, 0, 0);

    // saturation on the instance that starts at 16'hFFFE
    chk("sat_start", bus2.StallCount, 16'hFFFE);
    driveSat(1, 0, 0, 5, 1, 1); tick();
    driveSat(1, 0, 5, 5, 1, 1);
    chk("sat_stall1", bus2.Stall, 1'b1);
    tick();
    chk("sat_cnt1", bus2.StallCount, 16'hFFFF);
    chk("sat_ls_stall", bus2.Stall, 1'b0);
    tick();
    driveSat(1, 5, 0, 1, 1, 0);
    chk("sat_stall2", bus2.Stall, 1'b1);
    tick();
    chk("sat_cnt2", bus2.StallCount, 16'hFFFF);
    driveSat(0, 0, 0, 0, 0, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
